// File: rtl/tone_phase_gen.sv
// DDS phase-accumulator front end for the sine lookup table: turns a tone request
// into one table address per sample period, plus a strobe aligned to the table's registered Q.
module tone_phase_gen #(
    parameter int COUNT_SIZE = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int DUR_WIDTH  = 16,
    parameter int SAMPLE_DIV = 1563,
    parameter bit RETRIGGER  = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [ACC_WIDTH-1:0]  phase_inc,
    input  logic [DUR_WIDTH-1:0]  duration,
    input  logic                  abort,
    output logic [COUNT_SIZE-1:0] ADDR,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

    state_t                state_q;
    logic [ACC_WIDTH-1:0]  acc_q, inc_q, acc_d;
    logic [DUR_WIDTH-1:0]  rem_q;
    logic [PW-1:0]         presc_q;
    logic [COUNT_SIZE-1:0] addr_q;
    logic                  strobe_q, valid_q, busy_q, done_q;
    logic                  accept, tick;

    assign tick   = (state_q == PLAY) && (presc_q == PRESC_LAST);
    assign accept = start && !abort && (duration != '0) && ((state_q == IDLE) || RETRIGGER);
    assign acc_d  = acc_q + inc_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            inc_q    <= '0;
            rem_q    <= '0;
            presc_q  <= '0;
            addr_q   <= '0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // strobe from the previous edge always lands, even across an abort
            valid_q  <= strobe_q;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                acc_q   <= '0;
                rem_q   <= '0;
                presc_q <= '0;
                addr_q  <= '0;
                busy_q  <= 1'b0;
            end else if (accept) begin
                state_q  <= PLAY;
                inc_q    <= phase_inc;
                acc_q    <= '0;
                rem_q    <= duration;
                presc_q  <= '0;
                addr_q   <= '0;
                strobe_q <= 1'b1;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (tick) begin
                            presc_q <= '0;
                            if (rem_q > DUR_WIDTH'(1)) begin
                                acc_q    <= acc_d;
                                addr_q   <= acc_d[ACC_WIDTH-1 -: COUNT_SIZE];
                                rem_q    <= rem_q - 1'b1;
                                strobe_q <= 1'b1;
                            end else begin
                                // last sample already issued; hold ADDR one more cycle
                                state_q <= DRAIN;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    DRAIN: begin
                        state_q <= IDLE;
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        presc_q <= '0;
                    end
                endcase
            end
        end
    end

    assign ADDR         = addr_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_tone_phase_gen.sv
// Bench for tone_phase_gen: one instance per RETRIGGER setting sharing stimulus,
// checked against a sample-schedule model plus directed vectors.
module tb_tone_phase_gen;

    localparam int D = 4;

    logic        clk, resetN, start, abort;
    logic [23:0] phase_inc;
    logic [15:0] duration;
    logic [7:0]  addr0, addr1;
    logic        sv0, sv1, busy0, busy1, done0, done1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    tone_phase_gen #(.COUNT_SIZE(8), .ACC_WIDTH(24), .DUR_WIDTH(16), .SAMPLE_DIV(D), .RETRIGGER(1'b0)) u0 (
        .clk(clk), .resetN(resetN), .start(start), .phase_inc(phase_inc), .duration(duration),
        .abort(abort), .ADDR(addr0), .sample_valid(sv0), .busy(busy0), .done(done0));

    tone_phase_gen #(.COUNT_SIZE(8), .ACC_WIDTH(24), .DUR_WIDTH(16), .SAMPLE_DIV(D), .RETRIGGER(1'b1)) u1 (
        .clk(clk), .resetN(resetN), .start(start), .phase_inc(phase_inc), .duration(duration),
        .abort(abort), .ADDR(addr1), .sample_valid(sv1), .busy(busy1), .done(done1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a tone is (t0, inc, n); sample k is issued at t0+k*D with address
    // upper byte of k*inc, busy through t0+n*D, done at t0+n*D+1.
    typedef struct {
        bit      act;
        int      t0;
        longint  inc;
        int      n;
        bit      strobe;
        logic [7:0] addr;
        bit      sv, busy, done;
    } mdl_t;
    mdl_t m[2];

    typedef struct {
        int         rel;
        logic [7:0] addr;
        bit         sv, busy, done;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input int r, input int c);
        mdl_t s;
        bit   bp;
        int   rel, k;
        s  = m[r];
        bp = s.busy;
        if (!resetN) begin
            s = '{default: 0};
        end else begin
            s.sv = s.strobe;
            if (abort) s.act = 1'b0;
            else if (start && duration != 0 && (!bp || r == 1)) begin
                s.act = 1'b1; s.t0 = c; s.inc = longint'(phase_inc); s.n = int'(duration);
            end
            s.strobe = 1'b0; s.busy = 1'b0; s.done = 1'b0; s.addr = 8'h00;
            if (s.act) begin
                rel = c - s.t0;
                if (rel <= s.n * D) begin
                    k = rel / D;
                    if (k > s.n - 1) k = s.n - 1;
                    s.busy   = 1'b1;
                    s.addr   = 8'(((longint'(k) * s.inc) & 64'hFFFFFF) >> 16);
                    s.strobe = (rel % D == 0) && (rel / D < s.n);
                end else begin
                    s.done = 1'b1;
                    s.act  = 1'b0;
                end
            end
        end
        m[r] = s;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0, cyc);
        model_edge(1, cyc);
        #1;
        chk("mdl_r0", {21'd0, addr0, sv0, busy0, done0}, {21'd0, m[0].addr, m[0].sv, m[0].busy, m[0].done});
        chk("mdl_r1", {21'd0, addr1, sv1, busy1, done1}, {21'd0, m[1].addr, m[1].sv, m[1].busy, m[1].done});
    endtask

    task automatic idle(input int n);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_tone(input string nm, input logic [23:0] inc, input int dur, input int exp[8]);
        int got[$];
        bit fin;
        fin = 1'b0;
        start = 1'b1; phase_inc = inc; duration = 16'(dur);
        step();
        start = 1'b0;
        for (int i = 0; i < dur * D + 8 && !fin; i++) begin
            step();
            if (sv0) got.push_back(int'(addr0));
            if (done0) begin
                fin = 1'b1;
                chk({nm, "_addr_after_done"}, addr0, 0);
            end
        end
        chk({nm, "_done_seen"}, fin, 1);
        chk({nm, "_nsamples"}, got.size(), dur);
        for (int i = 0; i < dur && i < got.size(); i++) chk({nm, "_addr"}, got[i], exp[i]);
        step();
        chk({nm, "_done_1cyc"}, done0, 0);
        idle(2);
    endtask

    initial begin
        int base, rel, dcnt0, dcnt1, drel0, drel1;

        tv[0]  = '{0,  8'd0, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{1,  8'd0, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{2,  8'd0, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{4,  8'd1, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{5,  8'd1, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{8,  8'd2, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{9,  8'd2, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{12, 8'd3, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{13, 8'd3, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{16, 8'd3, 1'b0, 1'b1, 1'b0};
        tv[10] = '{17, 8'd0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{18, 8'd0, 1'b0, 1'b0, 1'b0};

        resetN = 1'b0; start = 1'b0; abort = 1'b0; phase_inc = '0; duration = '0;
        m[0] = '{default: 0};
        m[1] = '{default: 0};
        step(); step();
        chk("reset_outs", {addr0, sv0, busy0, done0, addr1, sv1, busy1, done1}, 0);
        #2 resetN = 1'b1;
        idle(3);

        // Test 1: table of per-edge expectations
        start = 1'b1; phase_inc = 24'h010000; duration = 16'd4;
        step();
        base = cyc;
        start = 1'b0;
        for (int r = 0; r <= 18; r++) begin
            if (r > 0) step();
            rel = cyc - base;
            for (int i = 0; i < 12; i++) begin
                if (tv[i].rel == rel) begin
                    chk("t1_vec", {addr0, sv0, busy0, done0}, {tv[i].addr, tv[i].sv, tv[i].busy, tv[i].done});
                end
            end
        end
        idle(2);

        // Tests 1-3 as address sequences
        run_tone("t1", 24'h010000, 4, '{0, 1, 2, 3, 0, 0, 0, 0});
        run_tone("t2", 24'h400000, 6, '{0, 64, 128, 192, 0, 64, 0, 0});
        run_tone("t3", 24'h008000, 5, '{0, 0, 1, 1, 2, 0, 0, 0});
        run_tone("t_inc0", 24'h000000, 3, '{0, 0, 0, 0, 0, 0, 0, 0});

        // Test 4a: abort the edge after the 2nd address
        start = 1'b1; phase_inc = 24'h010000; duration = 16'd8;
        step();
        start = 1'b0;
        idle(4);
        chk("t4_second_addr", addr0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_abort_busy", busy0, 0);
        chk("t4_abort_addr", addr0, 0);
        chk("t4_pending_sv", sv0, 1);
        dcnt0 = 0;
        for (int i = 0; i < 40; i++) begin step(); if (done0) dcnt0++; end
        chk("t4_no_done", dcnt0, 0);

        // Test 4b: abort with start in IDLE
        start = 1'b1; abort = 1'b1; phase_inc = 24'h010000; duration = 16'd3;
        step();
        start = 1'b0; abort = 1'b0;
        chk("t4b_idle", {busy0, busy1}, 0);
        idle(3);
        chk("t4b_still_idle", {busy0, busy1, sv0, sv1}, 0);

        // Test 5: start while busy, both RETRIGGER settings
        start = 1'b1; phase_inc = 24'h010000; duration = 16'd3;
        step();
        base = cyc;
        start = 1'b0;
        idle(4);
        start = 1'b1; phase_inc = 24'h020000; duration = 16'd2;
        step();
        start = 1'b0;
        chk("t5_r0_keeps_addr", addr0, 1);
        chk("t5_r1_restart_addr", addr1, 0);
        chk("t5_r1_busy", busy1, 1);
        dcnt0 = 0; dcnt1 = 0; drel0 = -1; drel1 = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done0) begin dcnt0++; drel0 = cyc - base; end
            if (done1) begin dcnt1++; drel1 = cyc - base; end
        end
        chk("t5_r0_done_cnt", dcnt0, 1);
        chk("t5_r1_done_cnt", dcnt1, 1);
        chk("t5_r0_done_at", drel0, 13);
        chk("t5_r1_done_at", drel1, 14);

        // Test 6: async reset mid-PLAY
        start = 1'b1; phase_inc = 24'h030000; duration = 16'd10;
        step();
        start = 1'b0;
        idle(6);
        resetN = 1'b0;
        #1;
        chk("t6_async_clear", {addr0, sv0, busy0, done0, addr1, sv1, busy1, done1}, 0);
        step(); step();
        #2 resetN = 1'b1;
        idle(2);
        start = 1'b1; duration = 16'd0; phase_inc = 24'h010000;
        step();
        start = 1'b0;
        idle(4);
        chk("t6_dur0_ignored", {busy0, busy1, addr0, addr1}, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            start     = ($urandom % 6 == 0);
            phase_inc = ($urandom % 4 == 0) ? 24'h0 : 24'($urandom);
            duration  = 16'($urandom_range(0, 5));
            abort     = ($urandom % 30 == 0);
            step();
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
